bicubic_tap4_mac: RTL and testbench
===================================

// Module: bicubic_tap4_mac
// PURPOSE
//  Pipelined 4-tap bicubic dot product, CHANNELS lanes in parallel, sharing one set of 4 weight codes.
//  Full-precision successor to the single-tap truncating multiplier:
//   - products are not truncated;
//   - one rounding step after accumulation;
//   - result clamped to the pixel range.
//  Sits between the line-buffer window fetch and the output pixel stream, with a valid/ready interface.
// PARAMETERS
//  PIXEL_W   8  unsigned pixel magnitude width (4..12)
//  CHANNELS  3  parallel colour lanes
//  TAG_W     2  sideband passed through with data (e.g. SOL/EOL)
// PORTS
//  clk           in   1                   single clock, rising edge
//  rst           in   1                   synchronous reset, active-high
//  in_valid      in   1                   input beat valid
//  in_ready      out  1                   block accepts beat this cycle
//  in_pixel      in   CHANNELS*4*PIXEL_W  lane c, tap t at [(c*4+t)*PIXEL_W +: PIXEL_W], unsigned
//  in_wcode      in   12                  tap t weight code at [t*3 +: 3]
//  in_wsign      in   4                   tap t weight negative when 1
//  in_tag        in   TAG_W               sideband, delayed with data
//  out_valid     out  1                   result valid
//  out_ready     in   1                   downstream accepts
//  out_pixel     out  CHANNELS*PIXEL_W    lane c at [c*PIXEL_W +: PIXEL_W]
//  out_tag       out  TAG_W               sideband aligned with out_pixel
// BEHAVIOUR
//  - Weight table (units of 1/256), codes 0..7: 3, 17, 18, 28, 29, 109, 192, 248.
//  - Stage S1: per lane/tap product p = pixel*W, width PIXEL_W+8, exact.
//    A negative weight yields the signed product -p.
//  - Stage S2: signed sum of 4 products, width PIXEL_W+11.
//  - Stage S3 (output register): r = (sum + 128) >>> 8, arithmetic shift.
//    r<0 -> 0; r>2^PIXEL_W-1 -> 2^PIXEL_W-1.
//  - Latency 3 cycles: a beat accepted at edge N is presented with out_valid=1 after edge N+3, when not stalled.
//  - Stall: pipe_en = ~out_valid | out_ready. All stage registers advance only when pipe_en=1.
//  - in_ready = pipe_en, combinational. A beat is accepted when in_valid & in_ready.
//  - Bubbles travel as valid=0 stage bits. Bubbles collapse only while out_valid=0.
//  - While out_valid=1 & out_ready=0: out_pixel, out_tag and out_valid hold stable.
//    in_ready=0 and no beat is lost or duplicated.
//  - Simultaneous output accept and input accept in the same cycle is legal.
//    Full throughput is 1 beat/cycle.
//  - Reset: all stage valids=0; out_valid=0, out_pixel=0, out_tag=0.
//    in_ready=1 in the first cycle after reset.
//  - Reset mid-operation discards all in-flight beats. No output from a pre-reset beat ever appears.
//  - Data registers need no reset, but out_pixel/out_tag must read 0 until the first valid output.
//  - Weight codes and sign are sampled with the beat and carried per stage.
//    Changing them between beats is legal.
// STRUCTURE
//  - bicubic_pkg: WCODE_W=3, FRAC_BITS=8, ROUND_BIAS=128, and a function wcode_to_weight(code) returning the table above.
//  - Sub-module bicubic_wmul: combinational shift-add multiplier for one tap.
//    Input: pixel, code, sign. Output: signed exact product. Instantiated CHANNELS*4 times in S1.
//  - Top holds S1/S2/S3 registers, valid chain, tag chain and stall logic.
// TESTING (PIXEL_W=8, CHANNELS=3)
//  1. Interpolation, all lanes pixels 200:
//     codes {0,7,2,0}, signs {1,0,0,1} (weights -3, +248, +18, -3) -> out_pixel 203 in each lane, 3 cycles after accept.
//  2. Clamping:
//     - tap0 pixel 255, code 7 negative, other pixels 0 -> 0.
//     - all pixels 255, codes 6, positive -> 255.
//  3. Rounding, single tap code 0 positive, others 0:
//     - pixel 85 -> 1 (255+128=383>>8).
//     - pixel 42 -> 0 (254>>8).
//  4. Backpressure:
//     - Stream 6 beats at 1/cycle; hold out_ready=0 for 5 cycles after the first out_valid.
//     - Required: in_ready=0 during the hold, out_pixel/out_tag stable, and all 6 results emerge in order with correct tags.
//  5. Reset mid-stream: assert rst for 1 cycle with 3 beats in flight.
//     - Next cycle out_valid=0 and out_pixel=0.
//     - None of the 3 beats appears.
//     - A beat sent after reset emerges 3 cycles later.
//  6. Lane independence, lanes with pixels {10,20,30,40}, {0,0,0,0}, {255,255,255,255}:
//     codes {1,6,5,0} positive -> each lane matches the reference model exactly.

Source files
------------

// File: rtl/bicubic_pkg.sv
// Shared constants and the weight-code table for the 4-tap bicubic MAC.
package bicubic_pkg;

    localparam int WCODE_W    = 3;
    localparam int WEIGHT_W   = 8;
    localparam int FRAC_BITS  = 8;
    localparam int ROUND_BIAS = 128;
    localparam int TAPS       = 4;

    // Weight magnitudes in units of 1/256, indexed by the 3-bit code.
    function automatic logic [WEIGHT_W-1:0] wcode_to_weight(input logic [WCODE_W-1:0] code);
        logic [WEIGHT_W-1:0] weight;
        case (code)
            3'd0:    weight = 8'd3;
            3'd1:    weight = 8'd17;
            3'd2:    weight = 8'd18;
            3'd3:    weight = 8'd28;
            3'd4:    weight = 8'd29;
            3'd5:    weight = 8'd109;
            3'd6:    weight = 8'd192;
            default: weight = 8'd248;
        endcase
        return weight;
    endfunction

endpackage

// File: rtl/bicubic_tap4_mac_wmul.sv
// Combinational shift-add multiplier for one tap: exact signed pixel*weight product.
module bicubic_wmul
    import bicubic_pkg::*;
#(
    parameter int PIXEL_W = 8
) (
    input  logic [PIXEL_W-1:0]        i_pixel,
    input  logic [WCODE_W-1:0]        i_code,
    input  logic                      i_sign,
    output logic signed [PIXEL_W+8:0] o_prod
);

    logic [WEIGHT_W-1:0]         w_weight;
    logic [PIXEL_W+WEIGHT_W-1:0] w_mag;

    // NOTE: combinational logic uses blocking assignments with every output defaulted
    // first, so the accumulation reads its own updated value and no latch is inferred.
    always_comb begin
        w_weight = wcode_to_weight(i_code);
        w_mag    = '0;
        for (int b = 0; b < WEIGHT_W; b++) begin
            if (w_weight[b]) begin
                w_mag = w_mag + ({{WEIGHT_W{1'b0}}, i_pixel} << b);
            end
        end
        o_prod = i_sign ? -$signed({1'b0, w_mag}) : $signed({1'b0, w_mag});
    end

endmodule

// File: rtl/bicubic_tap4_mac.sv
// 3-stage 4-tap bicubic dot product over CHANNELS lanes: multiply, sum, round+clamp.
module bicubic_tap4_mac
    import bicubic_pkg::*;
#(
    parameter int PIXEL_W  = 8,
    parameter int CHANNELS = 3,
    parameter int TAG_W    = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [CHANNELS*TAPS*PIXEL_W-1:0] in_pixel,
    input  logic [TAPS*WCODE_W-1:0]        in_wcode,
    input  logic [TAPS-1:0]                in_wsign,
    input  logic [TAG_W-1:0]               in_tag,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [CHANNELS*PIXEL_W-1:0]    out_pixel,
    output logic [TAG_W-1:0]               out_tag
);

    localparam int PROD_W = PIXEL_W + 9;
    localparam int SUM_W  = PIXEL_W + 11;
    localparam int RND_W  = SUM_W + 1;

    logic                            w_pipe_en;
    logic signed [PROD_W-1:0]        w_prod   [CHANNELS][TAPS];
    logic signed [SUM_W-1:0]         w_sum    [CHANNELS];
    logic signed [RND_W-1:0]         w_round  [CHANNELS];
    logic [CHANNELS*PIXEL_W-1:0]     w_clamped;

    logic                            r_s1_valid, r_s2_valid, r_out_valid;
    logic [TAG_W-1:0]                r_s1_tag, r_s2_tag, r_out_tag;
    logic signed [PROD_W-1:0]        r_s1_prod [CHANNELS][TAPS];
    logic signed [SUM_W-1:0]         r_s2_sum  [CHANNELS];
    logic [CHANNELS*PIXEL_W-1:0]     r_out_pixel;

    // One global enable: bubbles only collapse while the output register is empty.
    assign w_pipe_en = ~r_out_valid | out_ready;
    assign in_ready  = w_pipe_en;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        for (genvar t = 0; t < TAPS; t++) begin : g_tap
            bicubic_wmul #(.PIXEL_W(PIXEL_W)) u_wmul (
                .i_pixel (in_pixel[(c*TAPS+t)*PIXEL_W +: PIXEL_W]),
                .i_code  (in_wcode[t*WCODE_W +: WCODE_W]),
                .i_sign  (in_wsign[t]),
                .o_prod  (w_prod[c][t])
            );
        end
    end

    always_comb begin
        w_clamped = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_sum[c] = '0;
            for (int t = 0; t < TAPS; t++) begin
                w_sum[c] = w_sum[c] + SUM_W'(r_s1_prod[c][t]);
            end
            w_round[c] = (RND_W'(r_s2_sum[c]) + RND_W'(ROUND_BIAS)) >>> FRAC_BITS;
            if (w_round[c][RND_W-1]) begin
                w_clamped[c*PIXEL_W +: PIXEL_W] = '0;
            end else if (|w_round[c][RND_W-2:PIXEL_W]) begin
                w_clamped[c*PIXEL_W +: PIXEL_W] = {PIXEL_W{1'b1}};
            end else begin
                w_clamped[c*PIXEL_W +: PIXEL_W] = w_round[c][PIXEL_W-1:0];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; the output data only loads on a valid beat so it reads 0 until then.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_pixel <= '0;
            r_out_tag   <= '0;
        end else if (w_pipe_en) begin
            r_s1_valid  <= in_valid;
            r_s2_valid  <= r_s1_valid;
            r_out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_out_pixel <= w_clamped;
                r_out_tag   <= r_s2_tag;
            end
        end
    end

    // NOTE: intermediate data registers carry no reset; the valid chain alone decides
    // whether their contents mean anything.
    always_ff @(posedge clk) begin
        if (w_pipe_en) begin
            if (in_valid) begin
                r_s1_prod <= w_prod;
                r_s1_tag  <= in_tag;
            end
            if (r_s1_valid) begin
                r_s2_sum <= w_sum;
                r_s2_tag <= r_s1_tag;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_pixel = r_out_pixel;
    assign out_tag   = r_out_tag;

endmodule

// File: tb/tb_bicubic_tap4_mac.sv
// Scoreboard bench for bicubic_tap4_mac: a driver queues beats, a monitor pops and compares.
module tb_bicubic_tap4_mac;

    localparam int PIXEL_W  = 8;
    localparam int CHANNELS = 3;
    localparam int TAG_W    = 2;
    localparam int PMAX     = (1 << PIXEL_W) - 1;
    localparam int WTAB [8] = '{3, 17, 18, 28, 29, 109, 192, 248};

    typedef struct {
        logic [CHANNELS*4*PIXEL_W-1:0] pixel;
        logic [11:0]                   wcode;
        logic [3:0]                    wsign;
        logic [TAG_W-1:0]              tag;
        logic [CHANNELS*PIXEL_W-1:0]   exp_pixel;
        bit                            keep;
        bit                            chk_lat;
    } beat_t;

    typedef struct {
        logic [CHANNELS*PIXEL_W-1:0] pixel;
        logic [TAG_W-1:0]            tag;
        bit                          chk_lat;
        int                          acc_cyc;
    } exp_t;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          in_valid;
    logic                          in_ready;
    logic [CHANNELS*4*PIXEL_W-1:0] in_pixel;
    logic [11:0]                   in_wcode;
    logic [3:0]                    in_wsign;
    logic [TAG_W-1:0]              in_tag;
    logic                          out_valid;
    logic                          out_ready;
    logic [CHANNELS*PIXEL_W-1:0]   out_pixel;
    logic [TAG_W-1:0]              out_tag;

    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc      = 0;
    beat_t stim_q[$];
    exp_t  exp_q[$];
    bit    fire     = 1'b0;
    int    fire_cyc = 0;

    int px [CHANNELS][4];
    int cd [4];
    bit sg [4];

    bicubic_tap4_mac #(.PIXEL_W(PIXEL_W), .CHANNELS(CHANNELS), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixel  (in_pixel),
        .in_wcode  (in_wcode),
        .in_wsign  (in_wsign),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pixel (out_pixel),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int model_lane(input int c);
        int s;
        s = 0;
        for (int t = 0; t < 4; t++) begin
            s += (sg[t] ? -1 : 1) * px[c][t] * WTAB[cd[t]];
        end
        if (s + 128 < 0) return 0;
        s = (s + 128) / 256;
        return (s > PMAX) ? PMAX : s;
    endfunction

    task automatic set_all(input int p);
        for (int c = 0; c < CHANNELS; c++)
            for (int t = 0; t < 4; t++) px[c][t] = p;
    endtask

    task automatic set_tap0(input int p);
        for (int c = 0; c < CHANNELS; c++)
            for (int t = 0; t < 4; t++) px[c][t] = (t == 0) ? p : 0;
    endtask

    // exp_all < 0 means every lane takes its value from the reference model.
    task automatic add_beat(input int tag, input int exp_all, input bit keep, input bit lat);
        beat_t b;
        int    pv, ev, cv, tv;
        for (int c = 0; c < CHANNELS; c++) begin
            for (int t = 0; t < 4; t++) begin
                pv = px[c][t];
                b.pixel[(c*4+t)*PIXEL_W +: PIXEL_W] = pv[PIXEL_W-1:0];
            end
            ev = (exp_all < 0) ? model_lane(c) : exp_all;
            b.exp_pixel[c*PIXEL_W +: PIXEL_W] = ev[PIXEL_W-1:0];
        end
        for (int t = 0; t < 4; t++) begin
            cv = cd[t];
            b.wcode[t*3 +: 3] = cv[2:0];
            b.wsign[t]        = sg[t];
        end
        tv        = tag;
        b.tag     = tv[TAG_W-1:0];
        b.keep    = keep;
        b.chk_lat = lat;
        stim_q.push_back(b);
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while ((stim_q.size() != 0 || exp_q.size() != 0) && k < 60) begin
            @(posedge clk); #1;
            k++;
        end
        check(name, 64'(stim_q.size() + exp_q.size()), 64'd0);
    endtask

    // Driver: presents the head of stim_q, pops it when the handshake completes.
    initial begin
        exp_t e;
        in_valid = 1'b0;
        in_pixel = '0;
        in_wcode = '0;
        in_wsign = '0;
        in_tag   = '0;
        forever begin
            @(posedge clk);
            if (fire) begin
                if (stim_q[0].keep) begin
                    e.pixel   = stim_q[0].exp_pixel;
                    e.tag     = stim_q[0].tag;
                    e.chk_lat = stim_q[0].chk_lat;
                    e.acc_cyc = fire_cyc;
                    exp_q.push_back(e);
                end
                stim_q.delete(0);
            end
            #1;
            if (stim_q.size() > 0) begin
                in_pixel = stim_q[0].pixel;
                in_wcode = stim_q[0].wcode;
                in_wsign = stim_q[0].wsign;
                in_tag   = stim_q[0].tag;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            fire     = in_valid && in_ready && !rst;
            fire_cyc = cyc;
        end
    end

    // Monitor: every accepted output must match the head of the expected queue.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_output: got pixel 0x%0h tag %0d, want no output", out_pixel, out_tag);
            end else begin
                e = exp_q.pop_front();
                check("out_pixel", 64'(out_pixel), 64'(e.pixel));
                check("out_tag", 64'(out_tag), 64'(e.tag));
                if (e.chk_lat) check("latency", 64'(cyc - e.acc_cyc), 64'd3);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CHANNELS*PIXEL_W-1:0] hold_pix;
        int k;
        rst       = 1'b1;
        out_ready = 1'b1;
        cd = '{0, 0, 0, 0};
        sg = '{0, 0, 0, 0};
        set_all(0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_pixel", 64'(out_pixel), 64'd0);
        check("reset_out_tag", 64'(out_tag), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);

        // Interpolation: 200*(-3+248+18-3)=52000 -> (52000+128)>>8 = 203.
        set_all(200);
        cd = '{0, 7, 2, 0};
        sg = '{1, 0, 0, 1};
        add_beat(2, 203, 1'b1, 1'b1);
        wait_drain("drain_interp");

        // Clamping: -255*248 -> 0; 4*255*192 -> 765 -> 255.
        set_tap0(255);
        cd = '{7, 0, 0, 0};
        sg = '{1, 0, 0, 0};
        add_beat(1, 0, 1'b1, 1'b0);
        set_all(255);
        cd = '{6, 6, 6, 6};
        sg = '{0, 0, 0, 0};
        add_beat(3, 255, 1'b1, 1'b0);
        // Rounding: 85*3=255 -> 1; 42*3=126 -> 0.
        set_tap0(85);
        cd = '{0, 0, 0, 0};
        add_beat(0, 1, 1'b1, 1'b0);
        set_tap0(42);
        add_beat(1, 0, 1'b1, 1'b0);
        wait_drain("drain_clamp_round");

        // Backpressure: tap0 pixel p, code 6 -> (p*192+128)>>8.
        cd = '{6, 0, 0, 0};
        sg = '{0, 0, 0, 0};
        set_tap0(10);  add_beat(1, 8, 1'b1, 1'b0);
        set_tap0(50);  add_beat(2, 38, 1'b1, 1'b0);
        set_tap0(100); add_beat(3, 75, 1'b1, 1'b0);
        set_tap0(150); add_beat(0, 113, 1'b1, 1'b0);
        set_tap0(200); add_beat(1, 150, 1'b1, 1'b0);
        set_tap0(255); add_beat(2, 191, 1'b1, 1'b0);
        k = 0;
        while (!out_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("bp_first_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b0;
        hold_pix  = {CHANNELS{8'd8}};
        repeat (5) begin
            @(negedge clk);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_hold_pixel", 64'(out_pixel), 64'(hold_pix));
            check("bp_hold_tag", 64'(out_tag), 64'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_drain("drain_backpressure");

        // Reset mid-stream with three beats parked in the stalled pipe.
        out_ready = 1'b0;
        set_all(77);
        cd = '{6, 6, 6, 6};
        add_beat(3, 0, 1'b0, 1'b0);
        add_beat(3, 0, 1'b0, 1'b0);
        add_beat(3, 0, 1'b0, 1'b0);
        k = 0;
        while (stim_q.size() != 0 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("rst_beats_accepted", 64'(stim_q.size()), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_pixel", 64'(out_pixel), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        out_ready = 1'b1;
        set_tap0(100);
        cd = '{5, 0, 0, 0};
        sg = '{0, 0, 0, 0};
        // 100*109=10900 -> (10900+128)>>8 = 43.
        add_beat(2, 43, 1'b1, 1'b1);
        wait_drain("drain_reset");

        // Lane independence, per-lane reference model: expected {29, 0, 255}.
        px = '{'{10, 20, 30, 40}, '{0, 0, 0, 0}, '{255, 255, 255, 255}};
        cd = '{1, 6, 5, 0};
        sg = '{0, 0, 0, 0};
        add_beat(1, -1, 1'b1, 1'b0);
        wait_drain("drain_lanes");

        repeat (5) @(posedge clk);
        #1;
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
